gem_rx_w_frame_tracker: RTL and testbench

//  Sits directly upstream of gem_rx_w_status_encoder. Watches GEM RX FIFO-interface writes,

---
 rtl/gem_rx_pkg.sv | 34 +++
 rtl/gem_rx_w_rec_fifo.sv | 62 ++++++
 rtl/gem_rx_w_frame_tracker.sv | 152 +++++++++++++++
 tb/tb_gem_rx_w_frame_tracker.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gem_rx_pkg.sv
// gem_rx_pkg: shared types for the GEM RX write-side frame tracker.
// Record layout, tracker states and the length clamp helper.
package gem_rx_pkg;

  localparam int GEM_MAX_FRAME_LEN = 8191;

  typedef logic [44:0] rx_w_status_t;

  typedef struct packed {
    rx_w_status_t status;
    logic [12:0]  frame_length;
    logic         drop;
  } rx_rec_t;

  typedef enum logic [1:0] {
    IDLE,
    IN_FRAME,
    DISCARD
  } rx_trk_state_t;

  // GEM length wins when nonzero, else fall back to the beat count.
  function automatic logic [12:0] frame_len(
    input logic [13:0] st_len,
    input logic [11:0] words,
    input int          data_bytes
  );
    logic [15:0] raw;
    if (st_len != 14'd0) raw = {2'b00, st_len};
    else                 raw = 16'(int'(words) * data_bytes);
    if (raw > 16'(GEM_MAX_FRAME_LEN)) return 13'h1FFF;
    return raw[12:0];
  endfunction

endpackage

// File: rtl/gem_rx_w_rec_fifo.sv
// gem_rx_w_rec_fifo: first-word-fall-through record FIFO.
// A push into a full FIFO is taken when a pop happens in the same cycle.
module gem_rx_w_rec_fifo
  import gem_rx_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  rx_rec_t                  wr_rec,
  input  logic                     pop,
  output rx_rec_t                  rd_rec,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  rx_rec_t       mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          wr_en, rd_en;

  assign full   = (level_q == (AW+1)'(DEPTH));
  assign empty  = (level_q == '0);
  assign level  = level_q;
  assign rd_rec = mem_q[rd_ptr_q];

  // pointer and level bookkeeping
  always_comb begin
    wr_en    = push & (~full | pop);
    rd_en    = pop & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_en && !rd_en) level_d = level_q + (AW+1)'(1);
    if (!wr_en && rd_en) level_d = level_q - (AW+1)'(1);
  end

  // storage array, contents only meaningful when not empty
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_rec;
  end

  // pointer and level registers
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/gem_rx_w_frame_tracker.sv
// gem_rx_w_frame_tracker: tracks GEM RX frames and queues one
// {status, length, drop} record per completed or truncated frame.
module gem_rx_w_frame_tracker
  import gem_rx_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DATA_BYTES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_w_wr,
  input  logic        rx_w_sop,
  input  logic        rx_w_eop,
  input  logic        rx_w_err,
  input  logic        rx_w_flush,
  input  logic [44:0] rx_w_status,
  output logic        rx_w_overflow,
  output logic        st_valid,
  input  logic        st_ready,
  output logic [44:0] st_status,
  output logic [12:0] st_frame_length,
  output logic        st_drop,
  output logic [15:0] drop_count,
  output logic [15:0] proto_err_count
);
  localparam int LW = $clog2(DEPTH);

  rx_trk_state_t state_q, state_d;
  logic [11:0]   words_q, words_d, words_inc;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic [15:0]   perr_cnt_q, perr_cnt_d;
  logic          ovf_q, ovf_d;
  logic          push, pop, full, empty;
  logic          drop_inc, perr_inc, bad;
  logic [LW:0]   level;
  rx_rec_t       push_rec, head_rec;

  assign bad       = rx_w_status[14];
  assign pop       = ~empty & st_ready;
  assign words_inc = (words_q == 12'hFFF) ? words_q : words_q + 12'd1;

  // frame FSM: record generation and event flags
  always_comb begin
    state_d  = state_q;
    words_d  = words_q;
    push     = 1'b0;
    push_rec = '0;
    drop_inc = 1'b0;
    perr_inc = 1'b0;
    if (rx_w_flush) begin
      state_d = IDLE;
    end else if (rx_w_wr) begin
      unique case (state_q)
        IDLE: begin
          if (rx_w_sop && rx_w_eop) begin
            push                  = 1'b1;
            push_rec.status       = rx_w_status;
            push_rec.frame_length =
              frame_len(rx_w_status[13:0], 12'd1, DATA_BYTES);
            push_rec.drop         = rx_w_err | bad;
          end else if (rx_w_sop) begin
            state_d = full ? DISCARD : IN_FRAME;
            words_d = 12'd1;
          end else if (rx_w_eop) begin
            perr_inc = 1'b1;
          end
        end
        IN_FRAME: begin
          if (rx_w_eop) begin
            push                  = 1'b1;
            push_rec.status       = rx_w_status;
            push_rec.frame_length =
              frame_len(rx_w_status[13:0], words_inc, DATA_BYTES);
            push_rec.drop         = rx_w_err | bad;
            state_d               = IDLE;
          end else if (rx_w_sop) begin
            push                  = 1'b1;
            push_rec.status       = rx_w_status;
            push_rec.frame_length =
              frame_len(14'd0, words_q, DATA_BYTES);
            push_rec.drop         = 1'b1;
            perr_inc              = 1'b1;
            words_d               = 12'd1;
          end else begin
            words_d = words_inc;
          end
        end
        DISCARD: begin
          if (rx_w_eop) begin
            state_d  = IDLE;
            drop_inc = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
      if (push && full && !pop) drop_inc = 1'b1;
    end
  end

  // saturating counters and registered overflow flag
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    perr_cnt_d = perr_cnt_q;
    if (drop_inc && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    if (perr_inc && perr_cnt_q != 16'hFFFF) perr_cnt_d = perr_cnt_q + 16'd1;
    ovf_d = (level == (LW+1)'(DEPTH));
  end

  // state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      words_q    <= '0;
      drop_cnt_q <= '0;
      perr_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      words_q    <= words_d;
      drop_cnt_q <= drop_cnt_d;
      perr_cnt_q <= perr_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  gem_rx_w_rec_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .push   (push),
    .wr_rec (push_rec),
    .pop    (pop),
    .rd_rec (head_rec),
    .full   (full),
    .empty  (empty),
    .level  (level)
  );

  // head record, forced to zero while nothing is queued
  always_comb begin
    st_valid        = ~empty;
    st_status       = empty ? '0 : head_rec.status;
    st_frame_length = empty ? '0 : head_rec.frame_length;
    st_drop         = empty ? 1'b0 : head_rec.drop;
  end

  assign rx_w_overflow   = ovf_q;
  assign drop_count      = drop_cnt_q;
  assign proto_err_count = perr_cnt_q;

endmodule

// File: tb/tb_gem_rx_w_frame_tracker.sv
// tb_gem_rx_w_frame_tracker: table-driven frames plus corner sequences.
// Expected records go into a queue and are matched as the DUT pops them.
module tb_gem_rx_w_frame_tracker;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx_w_wr = 1'b0;
  logic        rx_w_sop = 1'b0;
  logic        rx_w_eop = 1'b0;
  logic        rx_w_err = 1'b0;
  logic        rx_w_flush = 1'b0;
  logic [44:0] rx_w_status = '0;
  logic        st_ready = 1'b0;
  logic        rx_w_overflow;
  logic        st_valid;
  logic [44:0] st_status;
  logic [12:0] st_frame_length;
  logic        st_drop;
  logic [15:0] drop_count;
  logic [15:0] proto_err_count;

  always #5 clock = ~clock;

  gem_rx_w_frame_tracker #(
    .DEPTH      (8),
    .DATA_BYTES (4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .rx_w_wr         (rx_w_wr),
    .rx_w_sop        (rx_w_sop),
    .rx_w_eop        (rx_w_eop),
    .rx_w_err        (rx_w_err),
    .rx_w_flush      (rx_w_flush),
    .rx_w_status     (rx_w_status),
    .rx_w_overflow   (rx_w_overflow),
    .st_valid        (st_valid),
    .st_ready        (st_ready),
    .st_status       (st_status),
    .st_frame_length (st_frame_length),
    .st_drop         (st_drop),
    .drop_count      (drop_count),
    .proto_err_count (proto_err_count)
  );

  typedef struct {
    logic [44:0] status;
    logic [12:0] len;
    logic        drop;
    bit          chk_st;
  } exp_t;

  typedef struct {
    int   nb;
    int   slen;
    logic bad;
    logic err;
    int   elen;
    logic edrop;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vt[9];
  int   errors = 0;
  int   checks = 0;
  int   npops = 0;
  int   base;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && st_valid && st_ready) begin
      npops++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got record len %0d expected none",
                 st_frame_length);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.chk_st) chk("sb_status", 64'(st_status), 64'(mon_e.status));
        chk("sb_len", 64'(st_frame_length), 64'(mon_e.len));
        chk("sb_drop", 64'(st_drop), 64'(mon_e.drop));
      end
    end
  end

  function automatic logic [44:0] mkst(input logic bad, input int len,
                                       input int tag);
    return {tag[29:0], bad, len[13:0]};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic beat(input logic s, input logic e, input logic er,
                      input logic [44:0] st);
    rx_w_wr     = 1'b1;
    rx_w_sop    = s;
    rx_w_eop    = e;
    rx_w_err    = er;
    rx_w_status = st;
    tick(1);
    rx_w_wr  = 1'b0;
    rx_w_sop = 1'b0;
    rx_w_eop = 1'b0;
    rx_w_err = 1'b0;
  endtask

  task automatic send(input int nb, input logic [44:0] st, input logic er);
    if (nb == 1) begin
      beat(1'b1, 1'b1, er, st);
    end else begin
      beat(1'b1, 1'b0, 1'b0, st);
      for (int k = 1; k < nb - 1; k++) beat(1'b0, 1'b0, 1'b0, st);
      beat(1'b0, 1'b1, er, st);
    end
  endtask

  task automatic push_exp(input logic [44:0] st, input int len,
                          input logic drop, input bit cs);
    exp_t e;
    e.status = st;
    e.len    = len[12:0];
    e.drop   = drop;
    e.chk_st = cs;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    rx_w_wr    = 1'b0;
    rx_w_flush = 1'b0;
    st_ready   = 1'b0;
    tick(2);
    exp_q.delete();
    reset = 1'b0;
  endtask

  task automatic drain();
    st_ready = 1'b1;
    for (int i = 0; i < 200 && (exp_q.size() != 0 || st_valid); i++)
      tick(1);
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    chk("drain_valid", 64'(st_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [44:0] st;
    vt[0] = '{17, 64,   1'b0, 1'b0, 64,   1'b0};
    vt[1] = '{1,  0,    1'b0, 1'b0, 4,    1'b0};
    vt[2] = '{1,  0,    1'b0, 1'b1, 4,    1'b1};
    vt[3] = '{5,  0,    1'b0, 1'b0, 20,   1'b0};
    vt[4] = '{3,  0,    1'b1, 1'b0, 12,   1'b1};
    vt[5] = '{2,  9000, 1'b0, 1'b0, 8191, 1'b0};
    vt[6] = '{4,  8191, 1'b0, 1'b0, 8191, 1'b0};
    vt[7] = '{4,  8192, 1'b0, 1'b0, 8191, 1'b0};
    vt[8] = '{1,  100,  1'b0, 1'b1, 100,  1'b1};

    do_reset();
    chk("rst_valid", 64'(st_valid), 64'd0);
    chk("rst_ovf", 64'(rx_w_overflow), 64'd0);
    chk("rst_status", 64'(st_status), 64'd0);
    chk("rst_len", 64'(st_frame_length), 64'd0);
    chk("rst_drop", 64'(st_drop), 64'd0);
    chk("rst_dropcnt", 64'(drop_count), 64'd0);
    chk("rst_perr", 64'(proto_err_count), 64'd0);

    // basic 17-beat frame, latency and hold
    st = mkst(1'b0, 64, 30'h155);
    beat(1'b1, 1'b0, 1'b0, st);
    for (int k = 0; k < 15; k++) beat(1'b0, 1'b0, 1'b0, st);
    chk("t1_pre_valid", 64'(st_valid), 64'd0);
    push_exp(st, 64, 1'b0, 1'b1);
    beat(1'b0, 1'b1, 1'b0, st);
    chk("t1_valid", 64'(st_valid), 64'd1);
    chk("t1_len", 64'(st_frame_length), 64'd64);
    tick(3);
    chk("t1_hold_len", 64'(st_frame_length), 64'd64);
    chk("t1_hold_status", 64'(st_status), 64'(st));
    drain();

    // table of frames
    for (int i = 0; i < 9; i++) begin
      st = mkst(vt[i].bad, vt[i].slen, 30'h200 + i);
      push_exp(st, vt[i].elen, vt[i].edrop, 1'b1);
      send(vt[i].nb, st, vt[i].err);
      tick(1);
    end
    drain();

    // fill, overflow, discard, pop one
    do_reset();
    for (int i = 0; i < 8; i++) begin
      st = mkst(1'b0, 0, 30'h300 + i);
      push_exp(st, 8, 1'b0, 1'b1);
      send(2, st, 1'b0);
    end
    tick(2);
    chk("t3_ovf", 64'(rx_w_overflow), 64'd1);
    send(3, mkst(1'b0, 0, 30'h3FF), 1'b0);
    chk("t3_dropcnt", 64'(drop_count), 64'd1);
    st_ready = 1'b1;
    tick(1);
    st_ready = 1'b0;
    tick(1);
    chk("t3_ovf_clear", 64'(rx_w_overflow), 64'd0);
    drain();

    // truncated frame then normal frame
    do_reset();
    st_ready = 1'b1;
    st = mkst(1'b0, 0, 30'h400);
    beat(1'b1, 1'b0, 1'b0, st);
    for (int k = 0; k < 3; k++) beat(1'b0, 1'b0, 1'b0, st);
    st = mkst(1'b0, 0, 30'h401);
    push_exp(st, 16, 1'b1, 1'b0);
    beat(1'b1, 1'b0, 1'b0, st);
    for (int k = 0; k < 3; k++) beat(1'b0, 1'b0, 1'b0, st);
    st = mkst(1'b0, 0, 30'h402);
    push_exp(st, 20, 1'b0, 1'b1);
    beat(1'b0, 1'b1, 1'b0, st);
    chk("t4_perr", 64'(proto_err_count), 64'd1);
    drain();

    // flush with a concurrent eop beat, then stray eop
    do_reset();
    st_ready = 1'b1;
    st = mkst(1'b0, 50, 30'h500);
    beat(1'b1, 1'b0, 1'b0, st);
    beat(1'b0, 1'b0, 1'b0, st);
    rx_w_flush = 1'b1;
    beat(1'b0, 1'b1, 1'b0, st);
    rx_w_flush = 1'b0;
    tick(1);
    chk("t5_flush_valid", 64'(st_valid), 64'd0);
    chk("t5_flush_perr", 64'(proto_err_count), 64'd0);
    beat(1'b0, 1'b1, 1'b0, st);
    tick(1);
    chk("t5_stray_valid", 64'(st_valid), 64'd0);
    chk("t5_perr", 64'(proto_err_count), 64'd1);
    chk("t5_dropcnt", 64'(drop_count), 64'd0);
    st = mkst(1'b0, 9000, 30'h501);
    push_exp(st, 8191, 1'b0, 1'b1);
    send(2, st, 1'b0);
    drain();

    // push into a full FIFO with a concurrent pop
    do_reset();
    base = npops;
    for (int i = 0; i < 7; i++) begin
      st = mkst(1'b0, 0, 30'h600 + i);
      push_exp(st, 8, 1'b0, 1'b1);
      send(2, st, 1'b0);
    end
    st = mkst(1'b0, 0, 30'h610);
    beat(1'b1, 1'b0, 1'b0, st);
    beat(1'b0, 1'b0, 1'b0, st);
    push_exp(st, 8, 1'b1, 1'b0);
    beat(1'b1, 1'b0, 1'b0, st);
    beat(1'b0, 1'b0, 1'b0, st);
    chk("t6_ovf", 64'(rx_w_overflow), 64'd1);
    chk("t6_perr", 64'(proto_err_count), 64'd1);
    st = mkst(1'b0, 0, 30'h611);
    push_exp(st, 12, 1'b0, 1'b1);
    st_ready = 1'b1;
    beat(1'b0, 1'b1, 1'b0, st);
    st_ready = 1'b0;
    chk("t6_dropcnt", 64'(drop_count), 64'd0);
    tick(1);
    chk("t6_ovf_hold", 64'(rx_w_overflow), 64'd1);
    drain();
    chk("t6_pops", 64'(npops - base), 64'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
